pong_renderer: RTL

- Display-side consumer of the pong game state.
- Generates 640x480@60 VGA timing, snapshots ball and paddle positions once per frame, and produces per-pixel colour for the ball, both paddles and a dashed centre line.
- Sits between the game logic (ball, paddle controllers) and the board VGA pins; reads ball_x_pos/ball_y_pos and the paddle positions.

---
 rtl/pong_pkg.sv | 27 ++
 rtl/vga_timing.sv | 84 ++++++++
 rtl/pong_renderer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong display path: default VGA geometry,
// colours and the power-on positions of the ball and paddles.
package pong_pkg;

  typedef logic [9:0] pos_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL       = 800;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL       = 525;

  localparam logic [11:0] COL_BLACK = 12'h000;
  localparam logic [11:0] COL_WHITE = 12'hFFF;
  localparam logic [11:0] COL_GREY  = 12'h888;

  localparam pos_t BALL_X_RST = 10'd320;
  localparam pos_t BALL_Y_RST = 10'd0;
  localparam pos_t PAD_Y_RST  = 10'd240;

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, h/v raster counters and registered sync/visible outputs,
// plus a strobe on the pixel tick that opens the first blanking line.
module vga_timing
  import pong_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic clk,
  input  logic reset_n,
  output pos_t h_cnt,
  output pos_t v_cnt,
  output logic vis,
  output logic first_blank,
  output logic hsync_p1,
  output logic vsync_p1,
  output logic vld_p1,
  output pos_t pixel_x_p1,
  output pos_t pixel_y_p1
);

  localparam int HT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_LO = H_VISIBLE + H_FRONT;
  localparam int HS_HI = HS_LO + H_SYNC - 1;
  localparam int VS_LO = V_VISIBLE + V_FRONT;
  localparam int VS_HI = VS_LO + V_SYNC - 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_p0;
  logic             tick;
  logic             hs_act;
  logic             vs_act;

  assign tick = (div_p0 == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_p0 <= '0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      div_p0 <= tick ? '0 : div_p0 + 1'b1;
      if (tick) begin
        if (h_cnt == pos_t'(HT - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == pos_t'(VT - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign hs_act      = (h_cnt >= pos_t'(HS_LO)) && (h_cnt <= pos_t'(HS_HI));
  assign vs_act      = (v_cnt >= pos_t'(VS_LO)) && (v_cnt <= pos_t'(VS_HI));
  assign vis         = (h_cnt < pos_t'(H_VISIBLE)) && (v_cnt < pos_t'(V_VISIBLE));
  assign first_blank = tick && (h_cnt == '0) && (v_cnt == pos_t'(V_VISIBLE));

  // p0 -> p1: every raster output registered from the same counter state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hsync_p1   <= 1'b1;
      vsync_p1   <= 1'b1;
      vld_p1     <= 1'b0;
      pixel_x_p1 <= '0;
      pixel_y_p1 <= '0;
    end else begin
      hsync_p1   <= !hs_act;
      vsync_p1   <= !vs_act;
      vld_p1     <= vis;
      pixel_x_p1 <= h_cnt;
      pixel_y_p1 <= v_cnt;
    end
  end

endmodule

// File: rtl/pong_renderer.sv
// Pong display renderer: frame-locked snapshot of ball/paddle positions and a
// per-pixel colour mux (ball, paddles, dashed centre line) over VGA timing.
module pong_renderer
  import pong_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int H_VISIBLE   = H_VISIBLE_DEF,
  parameter int H_FRONT     = H_FRONT_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BACK      = H_BACK_DEF,
  parameter int V_VISIBLE   = V_VISIBLE_DEF,
  parameter int V_FRONT     = V_FRONT_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BACK      = V_BACK_DEF,
  parameter int LEFT_PAD_X  = 100,
  parameter int RIGHT_PAD_X = 540,
  parameter int PAD_W       = 5,
  parameter int PAD_HALF    = 20,
  parameter int BALL_HALF   = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  ball_x_pos,
  input  logic [9:0]  ball_y_pos,
  input  logic [9:0]  left_paddle_pos,
  input  logic [9:0]  right_paddle_pos,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [11:0] rgb,
  output logic        frame_start
);

  pos_t        h_cnt;
  pos_t        v_cnt;
  logic        vis;
  logic        first_blank;
  pos_t        ball_x_sh;
  pos_t        ball_y_sh;
  pos_t        lpad_sh;
  pos_t        rpad_sh;
  logic [10:0] col;
  logic [10:0] row;
  logic        ball_hit;
  logic        lpad_hit;
  logic        rpad_hit;
  logic        centre_hit;
  logic [11:0] colour;
  logic [11:0] rgb_p1;
  logic        frame_start_p1;

  // Lower bound that saturates at zero instead of wrapping
  function automatic logic [10:0] sub_clamp(input logic [10:0] a, input int b);
    logic [10:0] bw;
    bw = 11'(b);
    return (a >= bw) ? a - bw : 11'd0;
  endfunction

  function automatic logic pad_hit(input logic [10:0] c, input logic [10:0] r,
                                   input int pad_x, input pos_t pad_y);
    logic [10:0] yw;
    yw = {1'b0, pad_y};
    return (c >= 11'(pad_x)) && (c <= 11'(pad_x + PAD_W)) &&
           (r >= sub_clamp(yw, PAD_HALF)) && (r <= yw + 11'(PAD_HALF));
  endfunction

  vga_timing #(
    .CLK_DIV   (CLK_DIV),
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clk         (clk),
    .reset_n     (reset_n),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .vis         (vis),
    .first_blank (first_blank),
    .hsync_p1    (hsync),
    .vsync_p1    (vsync),
    .vld_p1      (video_on),
    .pixel_x_p1  (pixel_x),
    .pixel_y_p1  (pixel_y)
  );

  // Shadows only move during blanking, so a frame never mixes two positions
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ball_x_sh <= BALL_X_RST;
      ball_y_sh <= BALL_Y_RST;
      lpad_sh   <= PAD_Y_RST;
      rpad_sh   <= PAD_Y_RST;
    end else if (first_blank) begin
      ball_x_sh <= ball_x_pos;
      ball_y_sh <= ball_y_pos;
      lpad_sh   <= left_paddle_pos;
      rpad_sh   <= right_paddle_pos;
    end
  end

  assign col = {1'b0, h_cnt};
  assign row = {1'b0, v_cnt};

  assign ball_hit = (col >= sub_clamp({1'b0, ball_x_sh}, BALL_HALF)) &&
                    (col <= {1'b0, ball_x_sh} + 11'(BALL_HALF)) &&
                    (row >= sub_clamp({1'b0, ball_y_sh}, BALL_HALF)) &&
                    (row <= {1'b0, ball_y_sh} + 11'(BALL_HALF));
  assign lpad_hit   = pad_hit(col, row, LEFT_PAD_X, lpad_sh);
  assign rpad_hit   = pad_hit(col, row, RIGHT_PAD_X, rpad_sh);
  assign centre_hit = ((col == 11'(H_VISIBLE / 2 - 1)) || (col == 11'(H_VISIBLE / 2))) &&
                      !v_cnt[3];

  always_comb begin
    colour = COL_BLACK;
    if (!vis)                      colour = COL_BLACK;
    else if (ball_hit)             colour = COL_WHITE;
    else if (lpad_hit || rpad_hit) colour = COL_WHITE;
    else if (centre_hit)           colour = COL_GREY;
  end

  // p0 -> p1: colour and snapshot strobe aligned with the raster outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rgb_p1         <= COL_BLACK;
      frame_start_p1 <= 1'b0;
    end else begin
      rgb_p1         <= colour;
      frame_start_p1 <= first_blank;
    end
  end

  assign rgb         = rgb_p1;
  assign frame_start = frame_start_p1;

endmodule
